// File: rtl/pipe_control.sv
// pipe_control: pipelined MIPS control decoder. Decodes ID, carries the control
// bundle through EX..WB, with load-use interlock, flush, illegal trap and syscall halt.
`default_nettype none

`ifndef ALU_OP_BIT
`define ALU_OP_BIT 4
`endif
`ifndef WTG_OP_BIT
`define WTG_OP_BIT 4
`endif
`ifndef MUX_ALU_DATAY_BIT
`define MUX_ALU_DATAY_BIT 2
`endif
`ifndef MUX_RF_REQA_BIT
`define MUX_RF_REQA_BIT 1
`endif
`ifndef MUX_RF_REQB_BIT
`define MUX_RF_REQB_BIT 1
`endif
`ifndef DM_OP_BIT
`define DM_OP_BIT 4
`endif
`ifndef MUX_RF_DATAW_BIT
`define MUX_RF_DATAW_BIT 2
`endif

module pipe_control #(
  parameter int NUM_STAGES      = 3,
  parameter bit LOAD_USE_STALL  = 1'b1,
  parameter bit HALT_ON_SYSCALL = 1'b1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           id_valid,
  output logic                           id_ready,
  input  logic [31:0]                    id_instr,
  input  logic                           flush,
  input  logic                           resume,
  output logic                           ex_valid,
  output logic                           mem_valid,
  output logic                           wb_valid,
  output logic [`ALU_OP_BIT-1:0]         ex_op_alu,
  output logic [`WTG_OP_BIT-1:0]         ex_op_wtg,
  output logic [`MUX_ALU_DATAY_BIT-1:0]  ex_mux_alu_data_y,
  output logic [`MUX_RF_REQA_BIT-1:0]    ex_mux_rf_req_a,
  output logic [`MUX_RF_REQB_BIT-1:0]    ex_mux_rf_req_b,
  output logic                           ex_syscall,
  output logic [`DM_OP_BIT-1:0]          mem_op_dm,
  output logic                           mem_w_en_dm,
  output logic                           wb_w_en_rf,
  output logic [4:0]                     wb_dst,
  output logic [`MUX_RF_DATAW_BIT-1:0]   wb_mux_rf_data_w,
  output logic                           wb_memtoreg,
  output logic                           illegal,
  output logic [7:0]                     illegal_cnt,
  output logic                           halted
);

  localparam logic [`ALU_OP_BIT-1:0] ALU_NOP = 4'd0, ALU_ADD = 4'd1, ALU_SUB = 4'd2,
    ALU_SLT = 4'd3, ALU_SLTU = 4'd4, ALU_AND = 4'd5, ALU_OR = 4'd6, ALU_XOR = 4'd7,
    ALU_NOR = 4'd8, ALU_SLL = 4'd9, ALU_SRL = 4'd10, ALU_SRA = 4'd11, ALU_LUI = 4'd12;
  localparam logic [`WTG_OP_BIT-1:0] WTG_OP_NOP = 4'd0, WTG_OP_J = 4'd1, WTG_OP_JR = 4'd2,
    WTG_OP_BEQ = 4'd3, WTG_OP_BNE = 4'd4, WTG_OP_BLEZ = 4'd5, WTG_OP_BGTZ = 4'd6,
    WTG_OP_BLTZ = 4'd7, WTG_OP_BGEZ = 4'd8;
  localparam logic [`MUX_ALU_DATAY_BIT-1:0] Y_RFB = 2'd0, Y_SEXT = 2'd1, Y_ZEXT = 2'd2,
    Y_SHAMT = 2'd3;
  localparam logic REQA_RT = 1'b1, REQB_RS = 1'b1;
  localparam logic [`DM_OP_BIT-1:0] DM_LB = 4'd1, DM_LH = 4'd2, DM_LW = 4'd3,
    DM_LBU = 4'd4, DM_LHU = 4'd5, DM_SB = 4'd6, DM_SH = 4'd7, DM_SW = 4'd8;
  localparam logic [`MUX_RF_DATAW_BIT-1:0] W_ALU = 2'd0, W_DM = 2'd1, W_PC8 = 2'd2;

  typedef struct packed {
    logic                          valid;
    logic [`ALU_OP_BIT-1:0]        op_alu;
    logic [`WTG_OP_BIT-1:0]        op_wtg;
    logic [`MUX_ALU_DATAY_BIT-1:0] mux_y;
    logic [`MUX_RF_REQA_BIT-1:0]   req_a;
    logic [`MUX_RF_REQB_BIT-1:0]   req_b;
    logic                          syscall;
    logic [`DM_OP_BIT-1:0]         op_dm;
    logic                          w_en_dm;
    logic                          w_en_rf;
    logic [4:0]                    dst;
    logic [`MUX_RF_DATAW_BIT-1:0]  mux_w;
    logic                          memtoreg;
  } ctrl_t;

  typedef enum logic [1:0] {S_RUN = 2'd0, S_DRAIN = 2'd1, S_HALT = 2'd2} state_t;

  logic [5:0] opcode, funct;
  logic [4:0] rs, rt, rd;
  logic       unused_shamt;
  ctrl_t      dec;
  logic       dec_illegal, reads_rs, reads_rt;
  ctrl_t      stage [1:NUM_STAGES];
  logic       hazard, take, load_ex, illegal_take;
  state_t     state, state_nxt;
  logic [3:0] drain_cnt, drain_cnt_nxt;

  assign opcode       = id_instr[31:26];
  assign rs           = id_instr[25:21];
  assign rt           = id_instr[20:16];
  assign rd           = id_instr[15:11];
  assign funct        = id_instr[5:0];
  assign unused_shamt = ^id_instr[10:6];

  always_comb begin
    dec         = '0;
    dec_illegal = 1'b0;
    reads_rs    = 1'b0;
    reads_rt    = 1'b0;
    dec.valid   = 1'b1;
    case (opcode)
      6'h00: begin
        dec.w_en_rf = 1'b1;
        dec.dst     = rd;
        reads_rs    = 1'b1;
        reads_rt    = 1'b1;
        case (funct)
          6'h00: begin dec.op_alu = ALU_SLL; dec.mux_y = Y_SHAMT; dec.req_a = REQA_RT; reads_rs = 1'b0; end
          6'h02: begin dec.op_alu = ALU_SRL; dec.mux_y = Y_SHAMT; dec.req_a = REQA_RT; reads_rs = 1'b0; end
          6'h03: begin dec.op_alu = ALU_SRA; dec.mux_y = Y_SHAMT; dec.req_a = REQA_RT; reads_rs = 1'b0; end
          6'h04: begin dec.op_alu = ALU_SLL; dec.req_a = REQA_RT; dec.req_b = REQB_RS; end
          6'h06: begin dec.op_alu = ALU_SRL; dec.req_a = REQA_RT; dec.req_b = REQB_RS; end
          6'h07: begin dec.op_alu = ALU_SRA; dec.req_a = REQA_RT; dec.req_b = REQB_RS; end
          6'h08: begin dec.op_wtg = WTG_OP_JR; dec.w_en_rf = 1'b0; reads_rt = 1'b0; end
          6'h0C: begin dec.syscall = 1'b1; dec.w_en_rf = 1'b0; reads_rs = 1'b0; reads_rt = 1'b0; end
          6'h20, 6'h21: dec.op_alu = ALU_ADD;
          6'h22, 6'h23: dec.op_alu = ALU_SUB;
          6'h24: dec.op_alu = ALU_AND;
          6'h25: dec.op_alu = ALU_OR;
          6'h26: dec.op_alu = ALU_XOR;
          6'h27: dec.op_alu = ALU_NOR;
          6'h2A: dec.op_alu = ALU_SLT;
          6'h2B: dec.op_alu = ALU_SLTU;
          default: dec_illegal = 1'b1;
        endcase
      end
      6'h01: begin dec.op_wtg = rt[0] ? WTG_OP_BGEZ : WTG_OP_BLTZ; reads_rs = 1'b1; end
      6'h02: dec.op_wtg = WTG_OP_J;
      6'h03: begin dec.op_wtg = WTG_OP_J; dec.w_en_rf = 1'b1; dec.dst = 5'd31; dec.mux_w = W_PC8; end
      6'h04: begin dec.op_wtg = WTG_OP_BEQ; reads_rs = 1'b1; reads_rt = 1'b1; end
      6'h05: begin dec.op_wtg = WTG_OP_BNE; reads_rs = 1'b1; reads_rt = 1'b1; end
      6'h06: begin dec.op_wtg = WTG_OP_BLEZ; reads_rs = 1'b1; end
      6'h07: begin dec.op_wtg = WTG_OP_BGTZ; reads_rs = 1'b1; end
      6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F: begin
        dec.w_en_rf = 1'b1;
        dec.dst     = rt;
        reads_rs    = (opcode != 6'h0F);
        case (opcode)
          6'h0A:   begin dec.op_alu = ALU_SLT;  dec.mux_y = Y_SEXT; end
          6'h0B:   begin dec.op_alu = ALU_SLTU; dec.mux_y = Y_SEXT; end
          6'h0C:   begin dec.op_alu = ALU_AND;  dec.mux_y = Y_ZEXT; end
          6'h0D:   begin dec.op_alu = ALU_OR;   dec.mux_y = Y_ZEXT; end
          6'h0E:   begin dec.op_alu = ALU_XOR;  dec.mux_y = Y_ZEXT; end
          6'h0F:   begin dec.op_alu = ALU_LUI;  dec.mux_y = Y_ZEXT; end
          default: begin dec.op_alu = ALU_ADD;  dec.mux_y = Y_SEXT; end
        endcase
      end
      6'h20, 6'h21, 6'h23, 6'h24, 6'h25: begin
        dec.op_alu   = ALU_ADD;
        dec.mux_y    = Y_SEXT;
        dec.w_en_rf  = 1'b1;
        dec.dst      = rt;
        dec.memtoreg = 1'b1;
        dec.mux_w    = W_DM;
        reads_rs     = 1'b1;
        case (opcode)
          6'h20:   dec.op_dm = DM_LB;
          6'h21:   dec.op_dm = DM_LH;
          6'h24:   dec.op_dm = DM_LBU;
          6'h25:   dec.op_dm = DM_LHU;
          default: dec.op_dm = DM_LW;
        endcase
      end
      6'h28, 6'h29, 6'h2B: begin
        dec.op_alu  = ALU_ADD;
        dec.mux_y   = Y_SEXT;
        dec.w_en_dm = 1'b1;
        reads_rs    = 1'b1;
        reads_rt    = 1'b1;
        dec.op_dm   = (opcode == 6'h28) ? DM_SB : (opcode == 6'h29) ? DM_SH : DM_SW;
      end
      default: dec_illegal = 1'b1;
    endcase
    if (dec.dst == 5'd0) dec.w_en_rf = 1'b0;
    if (dec_illegal) begin
      dec      = '0;
      reads_rs = 1'b0;
      reads_rt = 1'b0;
    end
  end

  // Only a load sitting in EX can create a hazard; one bubble resolves it.
  assign hazard = LOAD_USE_STALL && stage[1].valid && stage[1].memtoreg && (stage[1].dst != 5'd0) &&
                  ((reads_rs && (stage[1].dst == rs)) || (reads_rt && (stage[1].dst == rt)));

  assign id_ready     = (state == S_RUN) & ~(hazard & ~flush);
  assign take         = id_valid & id_ready & ~flush;
  assign load_ex      = take & ~dec_illegal;
  assign illegal_take = take & dec_illegal;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 1; i <= NUM_STAGES; i++) stage[i] <= '0;
    end else begin
      stage[1] <= load_ex ? dec : '0;
      for (int i = 2; i <= NUM_STAGES; i++) stage[i] <= stage[i-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      illegal     <= 1'b0;
      illegal_cnt <= 8'd0;
    end else begin
      illegal <= illegal_take;
      if (illegal_take && (illegal_cnt != 8'hFF)) illegal_cnt <= illegal_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_RUN;
      drain_cnt <= 4'd0;
    end else begin
      state     <= state_nxt;
      drain_cnt <= drain_cnt_nxt;
    end
  end

  // The counter reaches 0 while the syscall sits in WB; the next edge halts.
  always_comb begin
    state_nxt     = state;
    drain_cnt_nxt = drain_cnt;
    case (state)
      S_RUN: begin
        if (HALT_ON_SYSCALL && load_ex && dec.syscall) begin
          state_nxt     = S_DRAIN;
          drain_cnt_nxt = 4'(NUM_STAGES - 1);
        end
      end
      S_DRAIN: begin
        if (drain_cnt == 4'd0) state_nxt = S_HALT;
        else drain_cnt_nxt = drain_cnt - 4'd1;
      end
      S_HALT: if (resume) state_nxt = S_RUN;
      default: state_nxt = S_RUN;
    endcase
  end

  assign halted            = (state == S_HALT);
  assign ex_valid          = stage[1].valid;
  assign ex_op_alu         = stage[1].op_alu;
  assign ex_op_wtg         = stage[1].op_wtg;
  assign ex_mux_alu_data_y = stage[1].mux_y;
  assign ex_mux_rf_req_a   = stage[1].req_a;
  assign ex_mux_rf_req_b   = stage[1].req_b;
  assign ex_syscall        = stage[1].syscall;
  assign mem_valid         = stage[2].valid;
  assign mem_op_dm         = stage[2].op_dm;
  assign mem_w_en_dm       = stage[2].w_en_dm;
  assign wb_valid          = stage[NUM_STAGES].valid;
  assign wb_w_en_rf        = stage[NUM_STAGES].w_en_rf;
  assign wb_dst            = stage[NUM_STAGES].dst;
  assign wb_mux_rf_data_w  = stage[NUM_STAGES].mux_w;
  assign wb_memtoreg       = stage[NUM_STAGES].memtoreg;

endmodule

`default_nettype wire

// File: tb/tb_pipe_control.sv
// tb_pipe_control: directed checks of pipe_control in three configurations:
// [0] NS=3 stall/halt, [1] NS=5 stall/halt, [2] NS=3 no stall, syscall flows through.
`default_nettype none

module tb_pipe_control;
  localparam int N = 3;
  localparam logic [3:0] ALU_NOP = 4'd0, ALU_ADD = 4'd1, ALU_OR = 4'd6, ALU_SLL = 4'd9;
  localparam logic [3:0] WTG_NOP = 4'd0, WTG_J = 4'd1, WTG_BEQ = 4'd3, WTG_BLTZ = 4'd7, WTG_BGEZ = 4'd8;
  localparam logic [1:0] Y_RFB = 2'd0, Y_SEXT = 2'd1, Y_ZEXT = 2'd2, Y_SHAMT = 2'd3;
  localparam logic [3:0] DM_LW = 4'd3;
  localparam logic [31:0] I_ADDU = 32'h00221821, I_LW = 32'h8C240000, I_ADDU_DEP = 32'h00822821,
    I_BEQ = 32'h10220004, I_SW = 32'hAC230000, I_ILL = 32'hFC000000, I_SYSCALL = 32'h0000000C,
    I_JAL = 32'h0C000010, I_ADDIU_R0 = 32'h24000005;

  logic clk = 1'b0, rst = 1'b1, id_valid = 1'b0, flush = 1'b0, resume = 1'b0;
  logic [31:0] id_instr = 32'd0;
  logic id_ready [N], ex_valid [N], mem_valid [N], wb_valid [N], ex_syscall [N];
  logic [3:0] ex_op_alu [N], ex_op_wtg [N], mem_op_dm [N];
  logic [1:0] ex_mux_alu_data_y [N], wb_mux_rf_data_w [N];
  logic ex_mux_rf_req_a [N], ex_mux_rf_req_b [N], mem_w_en_dm [N], wb_w_en_rf [N], wb_memtoreg [N];
  logic [4:0] wb_dst [N];
  logic illegal [N], halted [N];
  logic [7:0] illegal_cnt [N];
  int checks = 0, fails = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    pipe_control #(
      .NUM_STAGES     (g == 1 ? 5 : 3),
      .LOAD_USE_STALL (g == 2 ? 1'b0 : 1'b1),
      .HALT_ON_SYSCALL(g == 2 ? 1'b0 : 1'b1)
    ) u_dut (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_ready(id_ready[g]), .id_instr(id_instr),
      .flush(flush), .resume(resume), .ex_valid(ex_valid[g]), .mem_valid(mem_valid[g]),
      .wb_valid(wb_valid[g]), .ex_op_alu(ex_op_alu[g]), .ex_op_wtg(ex_op_wtg[g]),
      .ex_mux_alu_data_y(ex_mux_alu_data_y[g]), .ex_mux_rf_req_a(ex_mux_rf_req_a[g]),
      .ex_mux_rf_req_b(ex_mux_rf_req_b[g]), .ex_syscall(ex_syscall[g]), .mem_op_dm(mem_op_dm[g]),
      .mem_w_en_dm(mem_w_en_dm[g]), .wb_w_en_rf(wb_w_en_rf[g]), .wb_dst(wb_dst[g]),
      .wb_mux_rf_data_w(wb_mux_rf_data_w[g]), .wb_memtoreg(wb_memtoreg[g]), .illegal(illegal[g]),
      .illegal_cnt(illegal_cnt[g]), .halted(halted[g])
    );
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    id_valid = 1'b0; flush = 1'b0; resume = 1'b0; id_instr = 32'd0;
    @(negedge clk) rst = 1'b1;
    @(posedge clk) #1 rst = 1'b0;
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    #2;
    for (int g = 0; g < N; g++) begin
      checks++; if ({ex_valid[g], mem_valid[g], wb_valid[g]} !== 3'b000) begin fails++; $display("FAIL reset_valids[%0d]: got %b expected 000", g, {ex_valid[g], mem_valid[g], wb_valid[g]}); end
      checks++; if ({halted[g], illegal[g], illegal_cnt[g]} !== 10'd0) begin fails++; $display("FAIL reset_status[%0d]: got %h expected 0", g, {halted[g], illegal[g], illegal_cnt[g]}); end
      checks++; if (ex_op_wtg[g] !== WTG_NOP || wb_w_en_rf[g] !== 1'b0) begin fails++; $display("FAIL reset_bundle[%0d]: wtg %h wen %b expected 0/0", g, ex_op_wtg[g], wb_w_en_rf[g]); end
    end
    @(posedge clk) #1 rst = 1'b0;
    #1;
    checks++; if (id_ready[0] !== 1'b1) begin fails++; $display("FAIL reset_id_ready: got %b expected 1", id_ready[0]); end
  endtask

  task automatic test_decode;
    logic [31:0] ins [7] = '{32'h00221821, 32'h20220005, 32'h34220005, 32'h04210008, 32'h04200008, 32'h08000010, 32'h00021900};
    logic [3:0]  alu [7] = '{ALU_ADD, ALU_ADD, ALU_OR, ALU_NOP, ALU_NOP, ALU_NOP, ALU_SLL};
    logic [3:0]  wtg [7] = '{WTG_NOP, WTG_NOP, WTG_NOP, WTG_BGEZ, WTG_BLTZ, WTG_J, WTG_NOP};
    logic [1:0]  ysel [7] = '{Y_RFB, Y_SEXT, Y_ZEXT, Y_RFB, Y_RFB, Y_RFB, Y_SHAMT};
    do_reset();
    for (int i = 0; i < 7; i++) begin
      id_valid = 1'b1; id_instr = ins[i];
      tick();
      checks++; if ({ex_valid[0], ex_op_alu[0], ex_op_wtg[0], ex_mux_alu_data_y[0]} !== {1'b1, alu[i], wtg[i], ysel[i]})
        begin fails++; $display("FAIL decode[%0d] %h: got v%b alu%h wtg%h y%h expected v1 alu%h wtg%h y%h", i, ins[i], ex_valid[0], ex_op_alu[0], ex_op_wtg[0], ex_mux_alu_data_y[0], alu[i], wtg[i], ysel[i]); end
    end
    id_valid = 1'b0;
  endtask

  task automatic test_addu_latency;
    do_reset();
    id_valid = 1'b1; id_instr = I_ADDU; #1;
    checks++; if (id_ready[0] !== 1'b1) begin fails++; $display("FAIL addu_ready: got %b expected 1", id_ready[0]); end
    tick(); id_valid = 1'b0;
    tick();
    checks++; if (mem_valid[0] !== 1'b1 || wb_valid[0] !== 1'b0) begin fails++; $display("FAIL addu_mem: got mem%b wb%b expected mem1 wb0", mem_valid[0], wb_valid[0]); end
    tick();
    checks++; if ({wb_valid[0], wb_w_en_rf[0], wb_dst[0], wb_memtoreg[0]} !== {1'b1, 1'b1, 5'd3, 1'b0})
      begin fails++; $display("FAIL addu_wb: got v%b wen%b dst%0d m2r%b expected v1 wen1 dst3 m2r0", wb_valid[0], wb_w_en_rf[0], wb_dst[0], wb_memtoreg[0]); end
    checks++; if (wb_valid[1] !== 1'b0) begin fails++; $display("FAIL addu_wb_ns5_early: got %b expected 0", wb_valid[1]); end
    tick(); tick();
    checks++; if (wb_valid[1] !== 1'b1 || wb_dst[1] !== 5'd3) begin fails++; $display("FAIL addu_wb_ns5: got v%b dst%0d expected v1 dst3", wb_valid[1], wb_dst[1]); end
  endtask

  task automatic test_load_use;
    do_reset();
    id_valid = 1'b1; id_instr = I_LW;
    tick();
    id_instr = I_ADDU_DEP; #1;
    checks++; if ({id_ready[0], id_ready[1], id_ready[2]} !== 3'b001) begin fails++; $display("FAIL lu_stall_ready: got %b expected 001", {id_ready[0], id_ready[1], id_ready[2]}); end
    tick();
    checks++; if (ex_valid[0] !== 1'b0 || ex_valid[2] !== 1'b1) begin fails++; $display("FAIL lu_bubble: got ex0=%b ex2=%b expected 0/1", ex_valid[0], ex_valid[2]); end
    checks++; if (mem_op_dm[0] !== DM_LW) begin fails++; $display("FAIL lu_mem_op: got %h expected %h", mem_op_dm[0], DM_LW); end
    checks++; if (id_ready[0] !== 1'b1) begin fails++; $display("FAIL lu_ready_after: got %b expected 1", id_ready[0]); end
    tick(); id_valid = 1'b0;
    checks++; if (ex_valid[0] !== 1'b1 || ex_op_alu[0] !== ALU_ADD) begin fails++; $display("FAIL lu_retry: got v%b alu%h expected v1 alu%h", ex_valid[0], ex_op_alu[0], ALU_ADD); end
    checks++; if ({wb_memtoreg[0], wb_dst[0], wb_mux_rf_data_w[0]} !== {1'b1, 5'd4, 2'd1}) begin fails++; $display("FAIL lu_lw_wb: got m2r%b dst%0d w%h expected m2r1 dst4 w1", wb_memtoreg[0], wb_dst[0], wb_mux_rf_data_w[0]); end
    tick();
    checks++; if (wb_valid[2] !== 1'b1 || wb_dst[2] !== 5'd5) begin fails++; $display("FAIL lu_nostall_wb: got v%b dst%0d expected v1 dst5", wb_valid[2], wb_dst[2]); end
    checks++; if (wb_valid[0] !== 1'b0) begin fails++; $display("FAIL lu_wb_bubble: got %b expected 0", wb_valid[0]); end
    tick();
    checks++; if ({wb_valid[0], wb_w_en_rf[0], wb_dst[0]} !== {1'b1, 1'b1, 5'd5}) begin fails++; $display("FAIL lu_late_wb: got v%b wen%b dst%0d expected v1 wen1 dst5", wb_valid[0], wb_w_en_rf[0], wb_dst[0]); end
  endtask

  task automatic test_wb_dst;
    do_reset();
    id_valid = 1'b1; id_instr = I_JAL; tick();
    id_instr = I_ADDIU_R0; tick();
    id_valid = 1'b0; tick();
    checks++; if ({wb_w_en_rf[0], wb_dst[0], wb_mux_rf_data_w[0]} !== {1'b1, 5'd31, 2'd2}) begin fails++; $display("FAIL jal_wb: got wen%b dst%0d w%h expected wen1 dst31 w2", wb_w_en_rf[0], wb_dst[0], wb_mux_rf_data_w[0]); end
    tick();
    checks++; if (wb_valid[0] !== 1'b1 || wb_w_en_rf[0] !== 1'b0) begin fails++; $display("FAIL r0_write: got v%b wen%b expected v1 wen0", wb_valid[0], wb_w_en_rf[0]); end
  endtask

  task automatic test_flush;
    int sw_seen = 0;
    do_reset();
    id_valid = 1'b1; id_instr = I_BEQ; tick();
    checks++; if (ex_op_wtg[0] !== WTG_BEQ) begin fails++; $display("FAIL flush_beq_ex: got %h expected %h", ex_op_wtg[0], WTG_BEQ); end
    id_instr = I_SW; flush = 1'b1; #1;
    checks++; if (id_ready[0] !== 1'b1) begin fails++; $display("FAIL flush_consume: got %b expected 1", id_ready[0]); end
    tick(); flush = 1'b0; id_valid = 1'b0;
    checks++; if (ex_valid[0] !== 1'b0) begin fails++; $display("FAIL flush_bubble: got %b expected 0", ex_valid[0]); end
    for (int k = 0; k < 4; k++) begin
      if (mem_w_en_dm[0] === 1'b1) sw_seen++;
      tick();
    end
    checks++; if (sw_seen !== 0) begin fails++; $display("FAIL flush_sw_dropped: got %0d writes expected 0", sw_seen); end
    id_valid = 1'b1; id_instr = I_LW; tick();
    id_instr = I_ADDU_DEP; flush = 1'b1; #1;
    checks++; if (id_ready[0] !== 1'b1) begin fails++; $display("FAIL flush_over_stall: got %b expected 1", id_ready[0]); end
    tick(); flush = 1'b0; id_valid = 1'b0;
    checks++; if (ex_valid[0] !== 1'b0 || mem_op_dm[0] !== DM_LW) begin fails++; $display("FAIL flush_over_stall_ex: got v%b dm%h expected v0 dm%h", ex_valid[0], mem_op_dm[0], DM_LW); end
  endtask

  task automatic test_illegal;
    int pulses = 0, bad = 0;
    do_reset();
    id_valid = 1'b1; id_instr = I_ILL; flush = 1'b1; tick();
    checks++; if (illegal[0] !== 1'b0 || illegal_cnt[0] !== 8'd0) begin fails++; $display("FAIL ill_flushed: got p%b cnt%0d expected p0 cnt0", illegal[0], illegal_cnt[0]); end
    flush = 1'b0;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (illegal[0] === 1'b1) pulses++;
      if (ex_valid[0] !== 1'b0 || mem_w_en_dm[0] !== 1'b0 || wb_w_en_rf[0] !== 1'b0) bad++;
      if (i == 0) begin
        checks++; if (illegal_cnt[0] !== 8'd1) begin fails++; $display("FAIL ill_first_cnt: got %0d expected 1", illegal_cnt[0]); end
      end
    end
    checks++; if (pulses !== 300) begin fails++; $display("FAIL ill_pulses: got %0d expected 300", pulses); end
    checks++; if (bad !== 0) begin fails++; $display("FAIL ill_no_writes: got %0d bad cycles expected 0", bad); end
    checks++; if (illegal_cnt[0] !== 8'd255) begin fails++; $display("FAIL ill_saturate: got %0d expected 255", illegal_cnt[0]); end
    id_valid = 1'b0; tick();
    checks++; if (illegal[0] !== 1'b0) begin fails++; $display("FAIL ill_pulse_end: got %b expected 0", illegal[0]); end
  endtask

  task automatic test_syscall;
    do_reset();
    id_valid = 1'b1; id_instr = I_SYSCALL; tick();
    id_valid = 1'b0; #1;
    checks++; if (ex_syscall[1] !== 1'b1 || ex_syscall[2] !== 1'b1) begin fails++; $display("FAIL sys_ex: got %b/%b expected 1/1", ex_syscall[1], ex_syscall[2]); end
    checks++; if (id_ready[1] !== 1'b0 || id_ready[2] !== 1'b1) begin fails++; $display("FAIL sys_drain_ready: got %b/%b expected 0/1", id_ready[1], id_ready[2]); end
    for (int k = 1; k <= 5; k++) begin
      flush = (k <= 2);
      tick();
      checks++; if (halted[1] !== (k >= 5) || halted[0] !== (k >= 3) || halted[2] !== 1'b0)
        begin fails++; $display("FAIL sys_halt_edge%0d: got %b%b%b expected %b%b0", k, halted[0], halted[1], halted[2], k >= 3, k >= 5); end
      if (k == 1) begin
        checks++; if (ex_syscall[2] !== 1'b0) begin fails++; $display("FAIL sys_flow_once: got %b expected 0", ex_syscall[2]); end
      end
      if (k == 4) begin
        checks++; if (wb_valid[1] !== 1'b1) begin fails++; $display("FAIL sys_in_wb: got %b expected 1", wb_valid[1]); end
      end
    end
    flush = 1'b0; resume = 1'b1; #1;
    checks++; if (id_ready[1] !== 1'b0) begin fails++; $display("FAIL sys_halt_ready: got %b expected 0", id_ready[1]); end
    tick(); resume = 1'b0; #1;
    checks++; if (halted[1] !== 1'b0 || id_ready[1] !== 1'b1 || halted[0] !== 1'b0) begin fails++; $display("FAIL sys_resume: got h%b r%b h0=%b expected h0 r1 h0=0", halted[1], id_ready[1], halted[0]); end
    checks++; if (id_ready[2] !== 1'b1) begin fails++; $display("FAIL sys_nohalt_ready: got %b expected 1", id_ready[2]); end
  endtask

  task automatic test_rst_drain;
    do_reset();
    id_valid = 1'b1; id_instr = I_ILL; tick();
    id_instr = I_SYSCALL; tick();
    id_valid = 1'b0; tick();
    checks++; if (id_ready[1] !== 1'b0 || mem_valid[1] !== 1'b1 || illegal_cnt[1] !== 8'd1)
      begin fails++; $display("FAIL rd_pre: got r%b mem%b cnt%0d expected r0 mem1 cnt1", id_ready[1], mem_valid[1], illegal_cnt[1]); end
    #2 rst = 1'b1; #1;
    checks++; if ({halted[1], ex_valid[1], mem_valid[1], wb_valid[1], illegal_cnt[1]} !== 12'd0)
      begin fails++; $display("FAIL rd_async: got h%b v%b%b%b cnt%0d expected all 0", halted[1], ex_valid[1], mem_valid[1], wb_valid[1], illegal_cnt[1]); end
    tick(); rst = 1'b0; #1;
    checks++; if (id_ready[1] !== 1'b1) begin fails++; $display("FAIL rd_run: got %b expected 1", id_ready[1]); end
  endtask

  initial begin
    test_reset();
    test_decode();
    test_addu_latency();
    test_load_use();
    test_wb_dst();
    test_flush();
    test_illegal();
    test_syscall();
    test_rst_drain();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
